mux_4t1_arbiter: RTL

Round-robin arbiter that shares one n-bit 4:1 multiplexer path among four requesters and sequences its select. It drives the mux `SEL` from a registered grant, presents the selected data downstream with a VALID/READY handshake, and returns a per-requester acknowledge. It sits between four data producers (e.g. register file, ALU, scratch RAM, input port) and a single consumer bus in the SolarRAT datapath.

---
 rtl/arb_pkg.sv | 11 +
 rtl/mux_4t1_nb.sv | 25 ++
 rtl/mux_4t1_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the 4:1 mux round-robin arbiter.
// State encoding and default sizing parameters.
package arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int N_DEF         = 8;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/mux_4t1_nb.sv
// Plain n-bit 4:1 multiplexer; data path shared by the arbiter.
// Purely combinational, select is a 2-bit index.
module mux_4t1_nb #(
  parameter int n = 8
) (
  input  logic [1:0]   SEL,
  input  logic [n-1:0] D0,
  input  logic [n-1:0] D1,
  input  logic [n-1:0] D2,
  input  logic [n-1:0] D3,
  output logic [n-1:0] D_OUT
);

  always_comb begin
    D_OUT = '0;
    unique case (SEL)
      2'd0: D_OUT = D0;
      2'd1: D_OUT = D1;
      2'd2: D_OUT = D2;
      2'd3: D_OUT = D3;
      default: D_OUT = '0;
    endcase
  end

endmodule

// File: rtl/mux_4t1_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux with VALID/READY output.
// Define ARB_BURST_EN to allow up to MAX_BURST transfers per grant.
module mux_4t1_arbiter
  import arb_pkg::*;
#(
  parameter int n         = N_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   REQ,
  input  logic [n-1:0] D0,
  input  logic [n-1:0] D1,
  input  logic [n-1:0] D2,
  input  logic [n-1:0] D3,
  input  logic         READY,
  output logic [3:0]   GNT,
  output logic [1:0]   SEL,
  output logic         VALID,
  output logic [n-1:0] D_OUT,
  output logic [3:0]   ACK
);

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_burst
    $error("MAX_BURST must be within 1..16");
  end

  logic       state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;
  logic [3:0] gnt_q;
  logic       valid_q;

  // {found, index} of first request at or after ptr, wrapping mod 4
  function automatic logic [2:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (req[idx] && !res[2]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [2:0] pick;
  logic       cont;
  logic       busy_end;

  assign pick = rr_pick(REQ, ptr_q);

`ifdef ARB_BURST_EN
  logic [3:0] bcnt_q;
  assign cont = REQ[sel_q] && (int'(bcnt_q) < MAX_BURST - 1);
`else
  assign cont = 1'b0;
`endif

  // Leave BUSY on a final transfer, or on abort when READY is low
  assign busy_end = READY ? !cont : !REQ[sel_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
`ifdef ARB_BURST_EN
      bcnt_q  <= 4'd0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick[2]) begin
            state_q <= ST_BUSY;
            sel_q   <= pick[1:0];
            gnt_q   <= 4'b0001 << pick[1:0];
            valid_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (busy_end) begin
            state_q <= ST_IDLE;
            ptr_q   <= sel_q + 2'd1;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
`ifdef ARB_BURST_EN
            bcnt_q  <= 4'd0;
          end else if (READY) begin
            bcnt_q  <= bcnt_q + 4'd1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [n-1:0] mux_out;

  mux_4t1_nb #(.n(n)) u_mux (
    .SEL   (sel_q),
    .D0    (D0),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .D_OUT (mux_out)
  );

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = valid_q;
  assign D_OUT = valid_q ? mux_out : '0;
  assign ACK   = gnt_q & {4{READY}};

endmodule
